// File: rtl/scandoubler_memarb.sv
// Memory arbiter for a scandoubler: one video-in write requester and one video-out
// row reader share a burst memory port, alternating at burst granularity when both wait.
module scandoubler_memarb #(
    parameter int HCNT_WIDTH = 10,
    parameter int BURST_LEN  = 8
) (
    input  logic                        clk_sys,
    input  logic                        reset,
    input  logic                        vidin_req,
    input  logic [1:0]                  vidin_frame,
    input  logic [HCNT_WIDTH-1:0]       vidin_x,
    input  logic [HCNT_WIDTH-1:0]       vidin_y,
    input  logic [15:0]                 vidin_d,
    output logic                        vidin_ack,
    input  logic                        vidout_req,
    input  logic [1:0]                  vidout_frame,
    input  logic [HCNT_WIDTH-1:0]       vidout_x,
    input  logic [HCNT_WIDTH-1:0]       vidout_y,
    output logic [15:0]                 vidout_d,
    output logic                        vidout_ack,
    output logic                        mem_req,
    output logic                        mem_we,
    output logic [2+2*HCNT_WIDTH-1:0]   mem_addr,
    output logic [15:0]                 mem_wdata,
    input  logic [15:0]                 mem_rdata,
    input  logic                        mem_ack
);

    localparam int AW = 2 + 2 * HCNT_WIDTH;
    localparam int CW = $clog2(BURST_LEN);
    localparam logic [CW-1:0] LAST_BEAT = CW'(BURST_LEN - 1);

    typedef enum logic [1:0] {
        IDLE,
        WR_BURST,
        RD_BURST
    } state_t;

    state_t                  r_state;
    state_t                  w_state_next;
    logic [CW-1:0]           r_beat;
    logic                    r_we;
    logic [AW-1:0]           r_addr;
    logic [1:0]              r_row_frame;
    logic [HCNT_WIDTH-1:0]   r_row_y;
    logic [HCNT_WIDTH-1:0]   r_rd_x;
    logic                    r_last_rd;
    logic                    r_term;
    logic                    r_vidout_req_d;

    logic                    w_rise;
    logic                    w_row_live;
    logic                    w_beat;
    logic                    w_burst_done;
    logic                    w_grant_rd;
    logic                    w_grant_wr;
    logic [AW-1:0]           w_rd_addr;

    // A row is live from its rising edge (coordinates bypassed that cycle) until vidout_req drops.
    assign w_rise       = vidout_req & ~r_vidout_req_d;
    assign w_row_live   = vidout_req & (w_rise | ~r_term);
    assign w_beat       = mem_ack & (r_state != IDLE);
    assign w_burst_done = w_beat & (r_beat == LAST_BEAT);
    assign w_rd_addr    = w_rise ? {vidout_frame, vidout_y, vidout_x}
                                 : {r_row_frame, r_row_y, r_rd_x};

    always_comb begin
        w_state_next = r_state;
        w_grant_rd   = 1'b0;
        w_grant_wr   = 1'b0;
        case (r_state)
            IDLE: begin
                if (w_row_live && (!vidin_req || !r_last_rd)) begin
                    w_grant_rd   = 1'b1;
                    w_state_next = RD_BURST;
                end else if (vidin_req) begin
                    w_grant_wr   = 1'b1;
                    w_state_next = WR_BURST;
                end
            end
            WR_BURST, RD_BURST: begin
                if (w_burst_done) begin
                    w_state_next = IDLE;
                end
            end
            default: w_state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk_sys) begin
        if (reset) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_ff @(posedge clk_sys) begin
        if (reset) begin
            r_beat         <= '0;
            r_we           <= 1'b0;
            r_addr         <= '0;
            r_row_frame    <= '0;
            r_row_y        <= '0;
            r_rd_x         <= '0;
            r_last_rd      <= 1'b0;
            r_term         <= 1'b1;
            r_vidout_req_d <= 1'b0;
        end else begin
            r_vidout_req_d <= vidout_req;

            if (w_rise) begin
                r_row_frame <= vidout_frame;
                r_row_y     <= vidout_y;
                r_rd_x      <= vidout_x;
                r_term      <= 1'b0;
            end else begin
                if (!vidout_req) begin
                    r_term <= 1'b1;
                end
                if (w_burst_done && r_state == RD_BURST) begin
                    r_rd_x <= r_rd_x + HCNT_WIDTH'(BURST_LEN);
                end
            end

            if (w_burst_done) begin
                r_beat    <= '0;
                r_last_rd <= (r_state == RD_BURST);
            end else if (w_beat) begin
                r_beat <= r_beat + CW'(1);
            end

            if (w_grant_rd) begin
                r_we   <= 1'b0;
                r_addr <= w_rd_addr;
            end else if (w_grant_wr) begin
                r_we   <= 1'b1;
                r_addr <= {vidin_frame, vidin_y, vidin_x};
            end
        end
    end

    assign mem_req    = (r_state != IDLE);
    assign mem_we     = r_we;
    assign mem_addr   = r_addr;
    assign mem_wdata  = vidin_d;
    assign vidin_ack  = mem_ack & (r_state == WR_BURST) & ~reset;
    assign vidout_ack = mem_ack & (r_state == RD_BURST) & w_row_live & ~reset;
    assign vidout_d   = mem_rdata;

endmodule

// File: tb/tb_scandoubler_memarb.sv
// Self-checking bench for scandoubler_memarb: directed vector table, hand-written
// corner sequences and a randomized run against a transaction-level reference model.
module tb_scandoubler_memarb;

    localparam int H  = 10;
    localparam int BL = 8;
    localparam int AW = 2 + 2 * H;

    logic            clk_sys = 1'b0;
    logic            reset;
    logic            vidin_req;
    logic [1:0]      vidin_frame;
    logic [H-1:0]    vidin_x, vidin_y;
    logic [15:0]     vidin_d;
    logic            vidin_ack;
    logic            vidout_req;
    logic [1:0]      vidout_frame;
    logic [H-1:0]    vidout_x, vidout_y;
    logic [15:0]     vidout_d;
    logic            vidout_ack;
    logic            mem_req, mem_we;
    logic [AW-1:0]   mem_addr;
    logic [15:0]     mem_wdata, mem_rdata;
    logic            mem_ack;

    always #5 clk_sys = ~clk_sys;

    scandoubler_memarb #(.HCNT_WIDTH(H), .BURST_LEN(BL)) dut (
        .clk_sys(clk_sys), .reset(reset),
        .vidin_req(vidin_req), .vidin_frame(vidin_frame), .vidin_x(vidin_x),
        .vidin_y(vidin_y), .vidin_d(vidin_d), .vidin_ack(vidin_ack),
        .vidout_req(vidout_req), .vidout_frame(vidout_frame), .vidout_x(vidout_x),
        .vidout_y(vidout_y), .vidout_d(vidout_d), .vidout_ack(vidout_ack),
        .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr),
        .mem_wdata(mem_wdata), .mem_rdata(mem_rdata), .mem_ack(mem_ack)
    );

    int checks   = 0;
    int failures = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=0x%0h required=0x%0h t=%0t", name, act, exp, $time);
        end
    endtask

    // Reference model: tracks the burst in flight as a countdown of remaining words,
    // plus the open row and the x where its next read burst starts.
    bit            m_busy, m_rd, m_we, m_last_rd, m_open, m_prev;
    int            m_left, m_nx;
    logic [AW-1:0] m_addr;
    logic [1:0]    m_rf;
    logic [H-1:0]  m_ry;

    task automatic model_reset();
        m_busy = 0; m_rd = 0; m_we = 0; m_last_rd = 0; m_open = 0; m_prev = 0;
        m_left = 0; m_nx = 0; m_addr = '0; m_rf = '0; m_ry = '0;
    endtask

    task automatic model_update();
        bit was_idle, rise, want_rd, want_wr;
        if (reset) begin
            model_reset();
            return;
        end
        was_idle = !m_busy;
        rise     = vidout_req && !m_prev;
        if (m_busy && mem_ack) begin
            m_left--;
            if (m_left == 0) begin
                m_busy    = 0;
                m_last_rd = m_rd;
                if (m_rd) m_nx = (m_nx + BL) % (1 << H);
            end
        end
        if (rise) begin
            m_rf = vidout_frame; m_ry = vidout_y; m_nx = int'(vidout_x); m_open = 1;
        end else if (!vidout_req) begin
            m_open = 0;
        end
        if (was_idle) begin
            want_rd = vidout_req && m_open;
            want_wr = vidin_req;
            if (want_rd && (!want_wr || !m_last_rd)) begin
                m_busy = 1; m_rd = 1; m_we = 0; m_left = BL;
                m_addr = {m_rf, m_ry, H'(m_nx)};
            end else if (want_wr) begin
                m_busy = 1; m_rd = 0; m_we = 1; m_left = BL;
                m_addr = {vidin_frame, vidin_y, vidin_x};
            end
        end
        m_prev = vidout_req;
    endtask

    // Event log of what the DUT actually did, used by the directed sequences.
    logic [AW:0] grants[$];
    int          n_iack, n_oack, n_mack;
    bit          prev_mreq = 0;

    task automatic clear_log();
        grants.delete();
        n_iack = 0; n_oack = 0; n_mack = 0;
    endtask

    task automatic cyc_check();
        bit rise, open_now;
        rise     = vidout_req && !m_prev;
        open_now = vidout_req && (rise || m_open);
        chk("mem_req",   32'(mem_req),   32'(m_busy));
        chk("mem_we",    32'(mem_we),    32'(m_we));
        chk("mem_addr",  32'(mem_addr),  32'(m_addr));
        chk("mem_wdata", 32'(mem_wdata), 32'(vidin_d));
        chk("vidin_ack", 32'(vidin_ack),
            32'(!reset && mem_ack && m_busy && !m_rd));
        chk("vidout_ack", 32'(vidout_ack),
            32'(!reset && mem_ack && m_busy && m_rd && open_now));
        if (vidout_ack) chk("vidout_d", 32'(vidout_d), 32'(mem_rdata));
        if (mem_req && !prev_mreq) grants.push_back({mem_we, mem_addr});
        prev_mreq = mem_req;
        if (vidin_ack) n_iack++;
        if (vidout_ack) n_oack++;
        if (mem_ack && mem_req) n_mack++;
    endtask

    task automatic cyc_end();
        model_update();
        @(posedge clk_sys);
        #1;
    endtask

    task automatic step();
        mem_rdata = 16'($urandom);
        vidin_d   = 16'($urandom);
        #4;
        cyc_check();
        cyc_end();
    endtask

    task automatic do_reset();
        reset = 1; vidin_req = 0; vidout_req = 0; mem_ack = 0;
        step(); step();
        reset = 0;
        clear_log();
    endtask

    typedef struct {
        bit            rst, ireq, oreq, ack;
        bit            e_req, e_we, e_iack, e_oack;
        logic [AW-1:0] e_addr;
    } vec_t;

    vec_t tbl[$];

    function automatic vec_t mk(bit rst, bit ireq, bit oreq, bit ack,
                                bit e_req, bit e_we, bit e_iack, bit e_oack,
                                logic [AW-1:0] e_addr);
        vec_t v;
        v.rst = rst; v.ireq = ireq; v.oreq = oreq; v.ack = ack;
        v.e_req = e_req; v.e_we = e_we; v.e_iack = e_iack; v.e_oack = e_oack;
        v.e_addr = e_addr;
        return v;
    endfunction

    initial begin : main
        logic [AW-1:0] a35;
        int n;

        reset = 1; vidin_req = 0; vidout_req = 0; mem_ack = 0;
        vidin_frame = 2'd1; vidin_y = H'(5); vidin_x = H'(16); vidin_d = '0;
        vidout_frame = '0; vidout_x = '0; vidout_y = '0; mem_rdata = '0;
        repeat (3) @(posedge clk_sys);
        #1;
        model_reset();

        // Write burst with acks every cycle, then reset landing on the 4th beat of a write.
        a35 = {2'd1, H'(5), H'(16)};
        tbl.push_back(mk(1, 0, 0, 1,  0, 0, 0, 0, '0));
        tbl.push_back(mk(1, 0, 0, 1,  0, 0, 0, 0, '0));
        tbl.push_back(mk(0, 1, 0, 1,  0, 0, 0, 0, '0));
        for (int i = 0; i < BL; i++) tbl.push_back(mk(0, 1, 0, 1,  1, 1, 1, 0, a35));
        tbl.push_back(mk(0, 0, 0, 1,  0, 1, 0, 0, a35));
        tbl.push_back(mk(0, 0, 0, 0,  0, 1, 0, 0, a35));
        tbl.push_back(mk(0, 1, 0, 0,  0, 1, 0, 0, a35));
        for (int i = 0; i < 3; i++) tbl.push_back(mk(0, 1, 0, 1,  1, 1, 1, 0, a35));
        tbl.push_back(mk(1, 1, 0, 1,  1, 1, 0, 0, a35));
        tbl.push_back(mk(0, 1, 0, 0,  0, 0, 0, 0, '0));
        for (int i = 0; i < BL; i++) tbl.push_back(mk(0, 1, 0, 1,  1, 1, 1, 0, a35));
        tbl.push_back(mk(0, 0, 0, 0,  0, 1, 0, 0, a35));

        clear_log();
        foreach (tbl[i]) begin
            reset = tbl[i].rst; vidin_req = tbl[i].ireq;
            vidout_req = tbl[i].oreq; mem_ack = tbl[i].ack;
            mem_rdata = 16'($urandom); vidin_d = 16'($urandom);
            #4;
            chk($sformatf("vec%0d_mem_req", i),    32'(mem_req),    32'(tbl[i].e_req));
            chk($sformatf("vec%0d_mem_we", i),     32'(mem_we),     32'(tbl[i].e_we));
            chk($sformatf("vec%0d_vidin_ack", i),  32'(vidin_ack),  32'(tbl[i].e_iack));
            chk($sformatf("vec%0d_vidout_ack", i), 32'(vidout_ack), 32'(tbl[i].e_oack));
            chk($sformatf("vec%0d_mem_addr", i),   32'(mem_addr),   32'(tbl[i].e_addr));
            cyc_check();
            cyc_end();
        end

        // Three read bursts from x=0.
        do_reset();
        vidout_frame = 2'd2; vidout_y = H'(7); vidout_x = '0;
        vidout_req = 1; mem_ack = 1;
        n = 0;
        while (n_oack < 3 * BL && n < 200) begin step(); n++; end
        chk("r36_timeout", 32'(n < 200), 32'd1);
        vidout_req = 0;
        repeat (12) step();
        chk("r36_oack_count", 32'(n_oack), 32'(3 * BL));
        chk("r36_grant_count", 32'(grants.size()), 32'd3);
        for (int i = 0; i < 3; i++) begin
            if (grants.size() > i) begin
                chk($sformatf("r36_addr%0d", i), 32'(grants[i][AW-1:0]),
                    32'({2'd2, H'(7), H'(i * BL)}));
                chk($sformatf("r36_we%0d", i), 32'(grants[i][AW]), 32'd0);
            end
        end

        // Both requesters raised together: strict alternation starting with the read.
        do_reset();
        vidin_frame = 2'd1; vidin_y = H'(3); vidin_x = H'(40);
        vidout_frame = 2'd0; vidout_y = H'(9); vidout_x = '0;
        vidin_req = 1; vidout_req = 1; mem_ack = 1;
        n = 0;
        while (grants.size() < 4 && n < 200) begin step(); n++; end
        chk("r37_timeout", 32'(n < 200), 32'd1);
        vidin_req = 0; vidout_req = 0;
        repeat (12) step();
        chk("r37_grant_count", 32'(grants.size()), 32'd4);
        for (int i = 0; i < 4; i++) begin
            if (grants.size() > i)
                chk($sformatf("r37_order%0d", i), 32'(grants[i][AW]), 32'(i % 2));
        end
        if (grants.size() > 2)
            chk("r37_second_read_x", 32'(grants[2][H-1:0]), 32'(BL));

        // Row dropped after the third read word of a burst.
        do_reset();
        vidout_frame = 2'd3; vidout_y = H'(1); vidout_x = H'(24);
        vidout_req = 1; mem_ack = 1;
        n = 0;
        while (n_oack < 3 && n < 50) begin step(); n++; end
        chk("r38_timeout", 32'(n < 50), 32'd1);
        vidout_req = 0;
        n = 0;
        while (mem_req && n < 50) begin step(); n++; end
        chk("r38_burst_words", 32'(n_mack), 32'(BL));
        repeat (20) step();
        chk("r38_oack_after_drop", 32'(n_oack), 32'd3);
        chk("r38_no_more_bursts", 32'(grants.size()), 32'd1);

        // Row start near the top of the x range: second burst wraps to x=0.
        do_reset();
        vidout_frame = 2'd1; vidout_y = H'(2); vidout_x = H'((1 << H) - BL);
        vidout_req = 1; mem_ack = 1;
        n = 0;
        while (grants.size() < 2 && n < 100) begin step(); n++; end
        chk("r39_timeout", 32'(n < 100), 32'd1);
        vidout_req = 0;
        repeat (12) step();
        if (grants.size() > 1) begin
            chk("r39_first_x", 32'(grants[0][H-1:0]), 32'((1 << H) - BL));
            chk("r39_wrapped_x", 32'(grants[1][H-1:0]), 32'd0);
        end else begin
            chk("r39_grant_count", 32'(grants.size()), 32'd2);
        end

        // Randomized traffic against the model.
        do_reset();
        for (int c = 0; c < 4000; c++) begin
            reset = ($urandom_range(0, 299) == 0);
            if (!vidin_req) begin
                vidin_frame = 2'($urandom); vidin_y = H'($urandom); vidin_x = H'($urandom);
                if ($urandom_range(0, 5) == 0) vidin_req = 1;
            end else if ($urandom_range(0, 19) == 0) begin
                vidin_req = 0;
            end
            if (!vidout_req) begin
                vidout_frame = 2'($urandom); vidout_y = H'($urandom);
                vidout_x = ($urandom_range(0, 2) == 0) ? H'((1 << H) - BL) : H'($urandom);
                if ($urandom_range(0, 7) == 0) vidout_req = 1;
            end else if ($urandom_range(0, 39) == 0) begin
                vidout_req = 0;
            end
            mem_ack = ($urandom_range(0, 2) != 0);
            step();
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/scandoubler_memarb.md
SCANDOUBLER_MEMARB -- requirements
Module: scandoubler_memarb

Interface
Parameters:
REQ-001 HCNT_WIDTH, default 10, width of the x/y coordinates carried by both requester ports.
REQ-002 BURST_LEN, default 8, words per memory burst; SHALL be a power of two, 2..16.
Ports:
REQ-003 clk_sys  in  1  single clock; all logic SHALL be synchronous to its rising edge.
REQ-004 reset  in  1  synchronous, active-high reset.
REQ-005 vidin_req  in  1  write requester; high until its BURST_LEN words are accepted.
REQ-006 vidin_frame / vidin_x / vidin_y  in  2 / HCNT_WIDTH / HCNT_WIDTH  write burst start coordinates, stable while vidin_req is high.
REQ-007 vidin_d  in  16  write data word.
REQ-008 vidin_ack  out  1  one-cycle pulse per write word accepted by memory.
REQ-009 vidout_req  in  1  read requester; high for a whole row.
REQ-010 vidout_frame / vidout_x / vidout_y  in  2 / HCNT_WIDTH / HCNT_WIDTH  row start coordinates, sampled on the vidout_req rising edge.
REQ-011 vidout_d  out  16  read data word, valid when vidout_ack is high.
REQ-012 vidout_ack  out  1  one-cycle pulse per valid read word.
REQ-013 mem_req  out  1  memory burst request, level, held for the whole burst.
REQ-014 mem_we  out  1  1 = write burst, 0 = read burst; stable while mem_req is high.
REQ-015 mem_addr  out  2+2*HCNT_WIDTH  word address {frame, y, x} at burst start; stable while mem_req is high.
REQ-016 mem_wdata  out  16  equals vidin_d.
REQ-017 mem_rdata  in  16  read data from memory.
REQ-018 mem_ack  in  1  one pulse per word transferred (write consumed, or read data valid).

Function
REQ-019 FSM states: IDLE, WR_BURST, RD_BURST. Arbitration SHALL occur only in IDLE.
REQ-020 IDLE, one requester pending -> grant it. Both pending -> grant vidout, unless the last completed burst was a read, in which case grant vidin (alternation at burst granularity).
REQ-021 "vidout pending" = vidout_req high AND row not yet terminated. "vidin pending" = vidin_req high.
REQ-022 On grant, mem_req SHALL rise on the cycle after the IDLE decision; mem_we and mem_addr SHALL be registered in that same cycle.
REQ-023 Write address = {vidin_frame, vidin_y, vidin_x}, sampled at grant.
REQ-024 Read address = {row frame, row y, rd_x}. rd_x SHALL load vidout_x on the vidout_req rising edge and SHALL advance by BURST_LEN at each completed read burst, modulo 2^HCNT_WIDTH (wraps silently).
REQ-025 A beat counter (log2(BURST_LEN) bits) SHALL count mem_ack pulses. On the BURST_LEN-th pulse: mem_req low on the next cycle, state returns to IDLE, counter cleared.
REQ-026 vidin_ack = mem_ack AND state==WR_BURST (combinational, zero latency).
REQ-027 vidout_ack = mem_ack AND state==RD_BURST AND row not terminated; vidout_d = mem_rdata (combinational).
REQ-028 If vidout_req falls mid read burst, the burst SHALL complete on the memory side, further vidout_ack SHALL be suppressed, and the row SHALL be marked terminated.
REQ-029 A new vidout_req rising edge SHALL clear the terminated flag and reload the row coordinates.
REQ-030 If vidin_req falls mid write burst, the burst SHALL still complete (memory cannot abort); the data presented on those beats is don't-care.
REQ-031 mem_ack received in IDLE SHALL be ignored: no requester ack and no counter change.
REQ-032 IDLE always lasts at least one cycle between bursts; back-to-back bursts are therefore separated by exactly one mem_req-low cycle.

Reset
REQ-033 While reset is high: state IDLE, mem_req=0, mem_we=0, mem_addr=0, beat counter=0, rd_x=0, last-burst flag=write, terminated flag=1, vidin_ack=0, vidout_ack=0.
REQ-034 Reset asserted mid burst SHALL drop mem_req on the next clock edge; the memory controller tolerates the truncated burst.

Verification
REQ-035 Reset, then vidin_req with frame=1, y=5, x=16; memory acks every cycle -> mem_we=1, mem_addr={1,5,16}, exactly 8 vidin_ack pulses, mem_req low after the 8th ack.
REQ-036 vidout_req with x=0, held for 3 bursts -> mem_addr x = 0, 8, 16; 24 vidout_ack pulses; vidout_d matches mem_rdata on each.
REQ-037 vidin_req and vidout_req asserted on the same cycle, both held -> grant order R, W, R, W; never two consecutive reads while vidin is pending.
REQ-038 vidout_req dropped after the 3rd ack of a burst -> mem_req held until the 8th mem_ack, no vidout_ack after the drop, no further read burst issued.
REQ-039 vidout_x = 2^HCNT_WIDTH - 8 -> second burst address x = 0 (wrap).
REQ-040 Reset pulsed during the 4th beat of a write -> mem_req=0 on the next cycle, all outputs at reset values, a new request is served normally afterwards.
